// File: rtl/arb_pkg.sv
// Shared arbiter-side definitions: default sizing, id width and grant decode helpers.
package arb_pkg;
    localparam int REQ_NUM_DEF    = 4;
    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_OK,
        GNT_MULTI,
        GNT_SPUR
    } gnt_kind_e;

    // Keep a 1-bit id for the degenerate single-channel case.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic is_onehot(input logic [31:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction
endpackage

// File: rtl/arb_req_agent_if.sv
// Requester/arbiter handshake bundle; slave is the agent, master is whoever drives it.
interface arb_req_agent_if
    import arb_pkg::*;
#(
    parameter int REQ_NUM = REQ_NUM_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ID_W    = id_w(REQ_NUM)
);
    logic [REQ_NUM-1:0]        in_valid;
    logic [REQ_NUM-1:0]        in_ready;
    logic [REQ_NUM*DATA_W-1:0] in_data;
    logic [REQ_NUM-1:0]        req;
    logic [REQ_NUM-1:0]        grant;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [ID_W-1:0]           out_id;

    modport master (
        output in_valid, in_data, grant,
        input  in_ready, req, out_valid, out_data, out_id
    );

    modport slave (
        input  in_valid, in_data, grant,
        output in_ready, req, out_valid, out_data, out_id
    );
endinterface

// File: rtl/arb_req_fifo.sv
// Per-channel sync FIFO; pointers carry an extra wrap bit to tell full from empty.
module arb_req_fifo
    import arb_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wptr, rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + 1'b1;
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: emptiness lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/arb_req_agent.sv
// Queues per-channel payloads, raises req from queue occupancy and returns the granted head.
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int REQ_NUM    = REQ_NUM_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int ID_W       = id_w(REQ_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    arb_req_agent_if.slave       bus,
    output logic                 err_multi,
    output logic                 err_spurious,
    output logic [15:0]          grant_cnt
);
    logic                             rdy_en;
    logic [REQ_NUM-1:0]               full, empty, push, pop;
    logic [REQ_NUM-1:0][DATA_W-1:0]   head;
    gnt_kind_e                        kind;
    logic [DATA_W-1:0]                sel_data;
    logic [ID_W-1:0]                  sel_id;

    // rdy_en holds in_ready low through reset and lifts it on the first edge after.
    assign bus.in_ready = {REQ_NUM{rdy_en}} & ~full;
    assign bus.req      = ~empty;
    assign push         = bus.in_valid & bus.in_ready;

    for (genvar g = 0; g < REQ_NUM; g++) begin : g_lane
        arb_req_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[g]),
            .wdata (bus.in_data[g*DATA_W +: DATA_W]),
            .pop   (pop[g]),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head[g])
        );
    end

    always_comb begin
        kind     = GNT_NONE;
        pop      = '0;
        sel_data = '0;
        sel_id   = '0;
        if (bus.grant != '0) begin
            if (!is_onehot(32'(bus.grant))) begin
                kind = GNT_MULTI;
            end else if ((bus.grant & bus.req) != '0) begin
                kind = GNT_OK;
                pop  = bus.grant;
            end else begin
                kind = GNT_SPUR;
            end
        end
        for (int i = 0; i < REQ_NUM; i++) begin
            if (bus.grant[i]) begin
                sel_data = head[i];
                sel_id   = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_en        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_id    <= '0;
            err_multi     <= 1'b0;
            err_spurious  <= 1'b0;
            grant_cnt     <= '0;
        end else begin
            rdy_en        <= 1'b1;
            bus.out_valid <= (kind == GNT_OK);
            if (kind == GNT_OK) begin
                bus.out_data <= sel_data;
                bus.out_id   <= sel_id;
                grant_cnt    <= grant_cnt + 16'd1;
            end
            if (kind == GNT_MULTI) err_multi    <= 1'b1;
            if (kind == GNT_SPUR)  err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_arb_req_agent.sv
// Bench for arb_req_agent: vector table, corner sequences, WRR-driven and random traffic vs queue model.
module tb_arb_req_agent;
    import arb_pkg::*;

    localparam int N = 4;
    localparam int W = 8;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        err_multi, err_spurious;
    logic [15:0] grant_cnt;

    always #5 clk = ~clk;

    arb_req_agent_if #(.REQ_NUM(N), .DATA_W(W)) bus ();

    arb_req_agent #(.REQ_NUM(N), .DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .err_multi    (err_multi),
        .err_spurious (err_spurious),
        .grant_cnt    (grant_cnt)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: one queue per channel plus the expected output registers.
    logic [7:0]  mq [N][$];
    logic        m_rdy_en = 1'b0;
    logic        m_ov = 1'b0;
    logic [7:0]  m_od = '0;
    logic [1:0]  m_oid = '0;
    logic        m_em = 1'b0, m_es = 1'b0;
    logic [15:0] m_cnt = '0;

    int rr_ptr = 0;
    int rr_used = 0;
    int wgt [N] = '{1, 2, 3, 1};

    typedef struct {
        logic [3:0]  v;
        logic [31:0] d;
        logic [3:0]  g;
        logic        ov;
        logic [7:0]  od;
        logic [1:0]  oid;
        logic [3:0]  rq;
        logic [3:0]  rdy;
        logic [15:0] cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [3:0] m_req();
        logic [3:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = (mq[i].size() > 0);
        return r;
    endfunction

    function automatic logic [3:0] m_ready();
        logic [3:0] r = '0;
        for (int i = 0; i < N; i++) r[i] = m_rdy_en && (mq[i].size() < D);
        return r;
    endfunction

    task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        logic [3:0] rq = m_req();
        logic [3:0] rd = m_ready();
        int pc = $countones(g);
        int idx = 0;
        m_ov = 1'b0;
        if (pc > 1) m_em = 1'b1;
        else if (pc == 1) begin
            for (int i = 0; i < N; i++) if (g[i]) idx = i;
            if (rq[idx]) begin
                m_od  = mq[idx].pop_front();
                m_oid = 2'(idx);
                m_ov  = 1'b1;
                m_cnt = m_cnt + 16'd1;
            end else m_es = 1'b1;
        end
        for (int i = 0; i < N; i++) if (v[i] && rd[i]) mq[i].push_back(d[i*8 +: 8]);
        m_rdy_en = 1'b1;
    endtask

    task automatic check_model();
        chk("in_ready", 32'(bus.in_ready), 32'(m_ready()));
        chk("req", 32'(bus.req), 32'(m_req()));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("out_data", 32'(bus.out_data), 32'(m_od));
        chk("out_id", 32'(bus.out_id), 32'(m_oid));
        chk("err_multi", 32'(err_multi), 32'(m_em));
        chk("err_spurious", 32'(err_spurious), 32'(m_es));
        chk("grant_cnt", 32'(grant_cnt), 32'(m_cnt));
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic cycle(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.grant    = g;
        model_step(v, d, g);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.grant    = '0;
        rst = 1'b1;
        #2;
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_req", 32'(bus.req), 32'h0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_out_data", 32'(bus.out_data), 32'h0);
        chk("rst_out_id", 32'(bus.out_id), 32'h0);
        chk("rst_err_multi", 32'(err_multi), 32'h0);
        chk("rst_err_spurious", 32'(err_spurious), 32'h0);
        chk("rst_grant_cnt", 32'(grant_cnt), 32'h0);
        for (int i = 0; i < N; i++) mq[i].delete();
        m_rdy_en = 1'b0; m_ov = 1'b0; m_od = '0; m_oid = '0;
        m_em = 1'b0; m_es = 1'b0; m_cnt = '0;
        @(negedge clk);
        rst = 1'b0;
        cycle(4'h0, 32'h0, 4'h0);
        chk("rdy_after_rst", 32'(bus.in_ready), 32'hF);
    endtask

    function automatic logic [3:0] wrr(input logic [3:0] r);
        if (r == '0) return 4'h0;
        if (!(r[rr_ptr] && rr_used < wgt[rr_ptr])) begin
            rr_used = 0;
            do rr_ptr = (rr_ptr + 1) % N; while (!r[rr_ptr]);
        end
        rr_used++;
        return 4'(1 << rr_ptr);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_pass %0d", n_pass);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.grant    = '0;
        #1;
        do_reset();

        // v, d, g -> out_valid, out_data, out_id, req, in_ready, grant_cnt
        tbl.push_back('{4'h4, 32'h0011_0000, 4'h0, 1'b0, 8'h00, 2'd0, 4'h4, 4'hF, 16'd0});
        tbl.push_back('{4'h4, 32'h0022_0000, 4'h0, 1'b0, 8'h00, 2'd0, 4'h4, 4'hF, 16'd0});
        tbl.push_back('{4'h0, 32'h0,         4'h4, 1'b1, 8'h11, 2'd2, 4'h4, 4'hF, 16'd1});
        tbl.push_back('{4'h0, 32'h0,         4'h4, 1'b1, 8'h22, 2'd2, 4'h0, 4'hF, 16'd2});
        tbl.push_back('{4'h0, 32'h0,         4'h0, 1'b0, 8'h22, 2'd2, 4'h0, 4'hF, 16'd2});
        tbl.push_back('{4'h1, 32'h0000_0001, 4'h0, 1'b0, 8'h22, 2'd2, 4'h1, 4'hF, 16'd2});
        tbl.push_back('{4'h1, 32'h0000_0002, 4'h0, 1'b0, 8'h22, 2'd2, 4'h1, 4'hF, 16'd2});
        tbl.push_back('{4'h1, 32'h0000_0003, 4'h0, 1'b0, 8'h22, 2'd2, 4'h1, 4'hF, 16'd2});
        tbl.push_back('{4'h1, 32'h0000_0004, 4'h0, 1'b0, 8'h22, 2'd2, 4'h1, 4'hE, 16'd2});
        tbl.push_back('{4'h1, 32'h0000_0005, 4'h0, 1'b0, 8'h22, 2'd2, 4'h1, 4'hE, 16'd2});
        tbl.push_back('{4'h0, 32'h0,         4'h1, 1'b1, 8'h01, 2'd0, 4'h1, 4'hF, 16'd3});
        tbl.push_back('{4'h0, 32'h0,         4'h1, 1'b1, 8'h02, 2'd0, 4'h1, 4'hF, 16'd4});
        tbl.push_back('{4'h0, 32'h0,         4'h1, 1'b1, 8'h03, 2'd0, 4'h1, 4'hF, 16'd5});
        tbl.push_back('{4'h0, 32'h0,         4'h1, 1'b1, 8'h04, 2'd0, 4'h0, 4'hF, 16'd6});
        foreach (tbl[k]) begin
            cycle(tbl[k].v, tbl[k].d, tbl[k].g);
            chk($sformatf("tbl%0d.out_valid", k), 32'(bus.out_valid), 32'(tbl[k].ov));
            chk($sformatf("tbl%0d.out_data", k), 32'(bus.out_data), 32'(tbl[k].od));
            chk($sformatf("tbl%0d.out_id", k), 32'(bus.out_id), 32'(tbl[k].oid));
            chk($sformatf("tbl%0d.req", k), 32'(bus.req), 32'(tbl[k].rq));
            chk($sformatf("tbl%0d.in_ready", k), 32'(bus.in_ready), 32'(tbl[k].rdy));
            chk($sformatf("tbl%0d.grant_cnt", k), 32'(grant_cnt), 32'(tbl[k].cnt));
        end

        // Full ch1: simultaneous push is refused, pop still happens.
        for (int i = 1; i <= 4; i++) cycle(4'h2, 32'(8'hA0 + i) << 8, 4'h0);
        chk("full_ch1_ready", 32'(bus.in_ready[1]), 32'h0);
        cycle(4'h2, 32'h0000_BB00, 4'h2);
        chk("full_pop_valid", 32'(bus.out_valid), 32'h1);
        chk("full_pop_data", 32'(bus.out_data), 32'hA1);
        chk("full_pop_ready", 32'(bus.in_ready[1]), 32'h1);
        for (int i = 2; i <= 4; i++) begin
            cycle(4'h0, 32'h0, 4'h2);
            chk($sformatf("full_drain%0d", i), 32'(bus.out_data), 32'(8'hA0 + i));
        end
        chk("full_drained_req", 32'(bus.req[1]), 32'h0);

        // Multi-bit grant: flagged, no pop, sticky.
        cycle(4'h3, 32'h0000_4131, 4'h0);
        cycle(4'h0, 32'h0, 4'h3);
        chk("multi_flag", 32'(err_multi), 32'h1);
        chk("multi_no_valid", 32'(bus.out_valid), 32'h0);
        chk("multi_cnt", 32'(grant_cnt), 32'd10);
        repeat (10) cycle(4'h0, 32'h0, 4'h0);
        chk("multi_sticky", 32'(err_multi), 32'h1);
        chk("multi_no_pop", 32'(bus.req), 32'h3);
        cycle(4'h0, 32'h0, 4'h1);
        chk("multi_ch0_head", 32'(bus.out_data), 32'h31);
        cycle(4'h0, 32'h0, 4'h2);
        chk("multi_ch1_head", 32'(bus.out_data), 32'h41);

        // Grant to an empty channel.
        cycle(4'h0, 32'h0, 4'h8);
        chk("spur_flag", 32'(err_spurious), 32'h1);
        chk("spur_no_valid", 32'(bus.out_valid), 32'h0);
        chk("spur_cnt", 32'(grant_cnt), 32'd12);

        // Push into empty ch3 with same-cycle grant: no pop, entry kept.
        cycle(4'h8, 32'h5500_0000, 4'h8);
        chk("pushgnt_no_valid", 32'(bus.out_valid), 32'h0);
        chk("pushgnt_req", 32'(bus.req[3]), 32'h1);
        cycle(4'h0, 32'h0, 4'h8);
        chk("pushgnt_data", 32'(bus.out_data), 32'h55);
        chk("pushgnt_id", 32'(bus.out_id), 32'h3);

        // WRR arbiter, in_valid pattern cycling 0..15, reset mid-run.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (c == 250) do_reset();
            cycle(4'(c % 16), $urandom, wrr(bus.req));
        end
        chk("wrr_err_multi", 32'(err_multi), 32'h0);
        chk("wrr_err_spurious", 32'(err_spurious), 32'h0);

        // Random traffic including illegal grants.
        do_reset();
        for (int c = 0; c < 300; c++) begin
            logic [3:0] g;
            g = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : wrr(bus.req);
            cycle(4'($urandom), $urandom, g);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
